// File: rtl/clk_ena_gen.sv
// clk_ena_gen: prescaler producing a single-cycle clock-enable tick every 2^(cks+1) clocks
module clk_ena_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cks,
  input  logic             div_en,
  output logic             clk_ena,
  output logic [CNT_W-1:0] div_phase
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, mask;
  logic [1:0] cks_act, cks_d;
  logic ena_d, due;
  // mask covers cnt[k:0]; a tick is due when those bits read 2^k - 1
  assign mask = CNT_W'((32'd2 << cks_act) - 32'd1);
  assign due = (cnt & mask) == (mask >> 1);
  assign div_phase = cnt;
  // next state: idle tracks the select, run counts; disable beats a select change, which restarts timing
  always_comb begin
    state_d = state;
    cnt_d = '0;
    ena_d = 1'b0;
    cks_d = cks_act;
    if (state == IDLE) begin
      cks_d = cks;
      if (div_en) state_d = RUN;
    end else if (!div_en) begin
      state_d = IDLE;
    end else if (cks != cks_act) begin
      cks_d = cks;
    end else begin
      cnt_d = cnt + 1'b1;
      ena_d = due;
    end
  end
  // state, counter, active select and registered tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      cks_act <= 2'd0;
      clk_ena <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      cks_act <= cks_d;
      clk_ena <= ena_d;
    end
  end
endmodule
